// File: rtl/lab6_pkg.sv
// Shared codes and state encoding for the lab6 master/slave pair.
package lab6_pkg;

  localparam logic [3:0] CODE_INVALID = 4'd8;
  localparam logic [3:0] CODE_OFF     = 4'd9;

  typedef enum logic [1:0] {
    S_OFF,
    S_LIT,
    S_ERR
  } state_t;

  function automatic state_t classify(input logic [3:0] code);
    if (code == CODE_OFF)
      return S_OFF;
    else if (code[3] == 1'b0)
      return S_LIT;
    else
      return S_ERR;
  endfunction

endpackage

// File: rtl/lab6_sync2.sv
// 4-bit two-flop synchronizer; resets to the OFF code.
module lab6_sync2
  import lab6_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= CODE_OFF;
      q    <= CODE_OFF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lab6_practice_slave.sv
// LED slave: synchronize, debounce and decode a 4-bit code from the master.
// Define LAB6_SYNC_EN to insert the two-flop input synchronizer.
module lab6_practice_slave
  import lab6_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  output logic [7:0] led,
  output logic       off,
  output logic       err,
  output logic [7:0] change_cnt
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [3:0] sync_code;
  logic [3:0] candidate;
  logic [3:0] accepted;
  logic [7:0] stable_cnt;
  state_t     state;
  state_t     next_state;
  logic       accept;

`ifdef LAB6_SYNC_EN
  lab6_sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (data_in),
    .q   (sync_code)
  );
`else
  assign sync_code = data_in;
`endif

  always_comb begin
    next_state = classify(candidate);
    accept     = (stable_cnt == CNT_MAX) && (candidate != accepted);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candidate  <= CODE_OFF;
      stable_cnt <= '0;
      accepted   <= CODE_OFF;
      state      <= S_OFF;
      led        <= '0;
      off        <= 1'b1;
      err        <= 1'b0;
      change_cnt <= '0;
    end else begin
      if (sync_code != candidate) begin
        candidate  <= sync_code;
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 8'd1;
      end

      if (accept) begin
        accepted <= candidate;
        state    <= next_state;
        off      <= (next_state == S_OFF);
        err      <= (next_state == S_ERR);
        // LIT->LIT rewrites the one-hot directly so no all-dark cycle appears
        if (next_state == S_LIT)
          led <= 8'(1) << candidate[2:0];
        else if (state == S_LIT)
          led <= '0;
        if (change_cnt != 8'hFF)
          change_cnt <= change_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lab6_practice_slave.sv
// Directed bench for lab6_practice_slave (latency follows LAB6_SYNC_EN).
module tb_lab6_practice_slave;

  localparam int unsigned STABLE = 4;
`ifdef LAB6_SYNC_EN
  localparam int unsigned LAT = STABLE + 3;
`else
  localparam int unsigned LAT = STABLE + 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic [7:0] led;
  logic       off;
  logic       err;
  logic [7:0] change_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  lab6_practice_slave #(.STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .led        (led),
    .off        (off),
    .err        (err),
    .change_cnt (change_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present code at a negedge; verify old LED one edge early, then full outputs at LAT.
  task automatic hold_check(input string tag, input logic [3:0] code, input logic [7:0] pre_led,
                            input logic [7:0] exp_led, input logic exp_off, input logic exp_err,
                            input logic [7:0] exp_cnt);
    data_in = code;
    repeat (LAT - 1) @(negedge clk);
    check({tag, "_pre"}, {24'd0, led}, {24'd0, pre_led});
    @(negedge clk);
    check({tag, "_led"}, {24'd0, led}, {24'd0, exp_led});
    check({tag, "_off"}, {31'd0, off}, {31'd0, exp_off});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_cnt"}, {24'd0, change_cnt}, {24'd0, exp_cnt});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    data_in = 4'd9;
    #1;
    check("rst_led", {24'd0, led}, 32'd0);
    check("rst_off", {31'd0, off}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cnt", {24'd0, change_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    hold_check("lit3", 4'd3, 8'h00, 8'h08, 1'b0, 1'b0, 8'd1);

    data_in = 4'd5;
    repeat (2) @(negedge clk);
    data_in = 4'd3;
    repeat (10) @(negedge clk);
    check("glitch_led", {24'd0, led}, 32'h08);
    check("glitch_cnt", {24'd0, change_cnt}, 32'd1);

    hold_check("off9", 4'd9, 8'h08, 8'h00, 1'b1, 1'b0, 8'd2);
    repeat (10) @(negedge clk);
    check("off9_again_cnt", {24'd0, change_cnt}, 32'd2);
    check("off9_again_off", {31'd0, off}, 32'd1);

    hold_check("inv8", 4'd8, 8'h00, 8'h00, 1'b0, 1'b1, 8'd3);
    hold_check("inv12", 4'd12, 8'h00, 8'h00, 1'b0, 1'b1, 8'd4);
    hold_check("lit3b", 4'd3, 8'h00, 8'h08, 1'b0, 1'b0, 8'd5);

    data_in = 4'd7;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      @(negedge clk);
      check("lit2lit_nodark", {31'd0, (led == 8'h08) || (led == 8'h80)}, 32'd1);
    end
    check("lit7_led", {24'd0, led}, 32'h80);
    check("lit7_cnt", {24'd0, change_cnt}, 32'd6);

    hold_check("lit0", 4'd0, 8'h80, 8'h01, 1'b0, 1'b0, 8'd7);
    hold_check("inv15", 4'd15, 8'h01, 8'h00, 1'b0, 1'b1, 8'd8);
    hold_check("inv10", 4'd10, 8'h00, 8'h00, 1'b0, 1'b1, 8'd9);

    data_in = 4'd6;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", {24'd0, led}, 32'd0);
    check("async_rst_off", {31'd0, off}, 32'd1);
    check("async_rst_err", {31'd0, err}, 32'd0);
    check("async_rst_cnt", {24'd0, change_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_check("post_rst6", 4'd6, 8'h00, 8'h40, 1'b0, 1'b0, 8'd1);

    for (int i = 0; i < 300; i++) begin
      data_in = (i % 2 == 0) ? 4'd1 : 4'd2;
      repeat (LAT) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("sat_cnt", {24'd0, change_cnt}, 32'd255);
    check("sat_led", {24'd0, led}, 32'h04);
    hold_check("sat_stick", 4'd1, 8'h04, 8'h02, 1'b0, 1'b0, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
